// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-seg driver: per-frame input snapshot, anti-ghost blanking
// at every digit change, and whole-display flashing while fail is high.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_BLANK | start of a digit slot, every anode off (anti-ghost gap)
//   ST_DRIVE | current digit's anode on with its snapshot pattern
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000,
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] dp_n,
  input  logic [3:0] digit_en,
  input  logic       fail,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = $clog2((SCAN_DIV > 2) ? SCAN_DIV : 2);
  localparam int FW = $clog2((FLASH_DIV > 2) ? FLASH_DIV : 2);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_slot_cnt;
  logic [SW-1:0]    w_slot_nxt;
  logic             w_slot_wrap;
  logic [1:0]       r_idx;
  logic [FW-1:0]    r_flash_cnt;
  logic             r_visible;
  logic             r_load_pend;
  logic             w_snap_load;
  logic [3:0][6:0]  r_snap_seg;
  logic [3:0]       r_snap_dp;
  logic [3:0]       r_snap_en;
  logic             w_show;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  always_comb begin
    w_slot_wrap = 1'b0;
    w_slot_nxt  = r_slot_cnt + 1'b1;
    w_state_nxt = r_state;
    w_snap_load = 1'b0;
    w_show      = 1'b0;
    w_an_nxt    = 4'b1111;
    w_seg_nxt   = 7'h7F;
    w_dp_nxt    = 1'b1;

    if (r_slot_cnt == SLOT_LAST) begin
      w_slot_wrap = 1'b1;
      w_slot_nxt  = '0;
    end
    // State tracks the slot position, so BLANK_CYC=0 simply never blanks.
    w_state_nxt = (w_slot_nxt < BLANK_END) ? ST_BLANK : ST_DRIVE;
    w_snap_load = r_load_pend | (w_slot_wrap & (r_idx == 2'd3));

    w_show = (r_state == ST_DRIVE) && r_visible && r_snap_en[r_idx];
    if (w_show) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = r_snap_seg[r_idx];
      w_dp_nxt  = r_snap_dp[r_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_BLANK;
      r_slot_cnt  <= '0;
      r_idx       <= 2'd0;
      r_load_pend <= 1'b1;
      r_snap_seg  <= {4{7'h7F}};
      r_snap_dp   <= 4'b1111;
      r_snap_en   <= 4'b0000;
      r_an        <= 4'b1111;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_nxt;
      if (w_slot_wrap) r_idx <= r_idx + 2'd1;
      if (w_snap_load) begin
        r_snap_seg  <= {seg3, seg2, seg1, seg0};
        r_snap_dp   <= dp_n;
        r_snap_en   <= digit_en;
        r_load_pend <= 1'b0;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  // Flash timer is independent of the scan so toggling never shifts digit timing.
  always_ff @(posedge clock) begin
    if (reset || !fail) begin
      r_flash_cnt <= '0;
      r_visible   <= 1'b1;
    end else if (r_flash_cnt == FLASH_LAST) begin
      r_flash_cnt <= '0;
      r_visible   <= ~r_visible;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
